// File: rtl/mem_access.sv
// rtl/mem_access.sv - MIPS data-memory stage: req/ack data-RAM access with stall, alignment and timeout handling
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Valid,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic        Stall,
    output logic [31:0] Ldata,
    output logic        Done,
    output logic        AlignErr,
    output logic        BusErr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [5:0]      lat_op;
    logic [1:0]      lat_lo;

    logic [5:0]  op;
    logic        is_mem;
    logic        is_store;
    logic        misaligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        start;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic        unused_bits;

    assign op          = Ins[31:26];
    assign unused_bits = ^Ins[25:0];

    always_comb begin
        is_mem     = 1'b1;
        is_store   = 1'b0;
        misaligned = 1'b0;
        be_c       = 4'b0000;
        wdata_c    = 32'h0;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                be_c    = 4'b0001 << Result[1:0];
                wdata_c = {4{Rdata2[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                misaligned = Result[0];
                be_c       = Result[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{Rdata2[15:0]}};
            end
            OP_LW, OP_SW: begin
                misaligned = |Result[1:0];
                be_c       = 4'b1111;
                wdata_c    = Rdata2;
            end
            default: is_mem = 1'b0;
        endcase
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    end

    assign start    = (state == S_IDLE) && Valid && is_mem && !misaligned;
    assign Stall    = RST && (start || (state == S_REQ));
    assign AlignErr = RST && (state == S_IDLE) && Valid && is_mem && misaligned;

    // Extraction uses the latched address/opcode; the live inputs may already have moved on.
    always_comb begin
        rd_byte  = 8'(dm_rdata >> {lat_lo, 3'b000});
        rd_half  = lat_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        load_ext = 32'h0;
        case (lat_op)
            OP_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_ext = {24'h0, rd_byte};
            OP_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_ext = {16'h0, rd_half};
            OP_LW:   load_ext = dm_rdata;
            default: load_ext = 32'h0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lat_op   <= 6'h0;
            lat_lo   <= 2'b00;
            Ldata    <= 32'h0;
            Done     <= 1'b0;
            BusErr   <= 1'b0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_be    <= 4'b0000;
            dm_addr  <= 32'h0;
            dm_wdata <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    Done   <= 1'b0;
                    BusErr <= 1'b0;
                    Ldata  <= 32'h0;
                    cnt    <= '0;
                    if (start) begin
                        dm_req   <= 1'b1;
                        dm_we    <= is_store;
                        dm_be    <= be_c;
                        dm_addr  <= {Result[31:2], 2'b00};
                        dm_wdata <= wdata_c;
                        lat_op   <= op;
                        lat_lo   <= Result[1:0];
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + 1'b1;
                    // Ack is checked first so an ack on the final allowed cycle beats the timeout.
                    if (dm_ack || (TIMEOUT != 0 && cnt == CNT_LAST)) begin
                        dm_req   <= 1'b0;
                        dm_we    <= 1'b0;
                        dm_be    <= 4'b0000;
                        dm_addr  <= 32'h0;
                        dm_wdata <= 32'h0;
                        Done     <= 1'b1;
                        BusErr   <= !dm_ack;
                        Ldata    <= dm_ack ? load_ext : 32'h0;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    Done   <= 1'b0;
                    BusErr <= 1'b0;
                    Ldata  <= 32'h0;
                    cnt    <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a behavioural model
module tb_mem_access;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Valid = 1'b0;
    logic [31:0] Ins = 32'h0;
    logic [31:0] Result = 32'h0;
    logic [31:0] Rdata2 = 32'h0;
    logic        Stall;
    logic [31:0] Ldata;
    logic        Done;
    logic        AlignErr;
    logic        BusErr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata = 32'h0;
    logic        dm_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam int TO = 16;

    mem_access #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .Valid(Valid), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
        .Stall(Stall), .Ldata(Ldata), .Done(Done), .AlignErr(AlignErr), .BusErr(BusErr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: access width in bytes, signedness and direction from the opcode, then plain arithmetic.
    task automatic model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rd2,
                         input logic [31:0] rdata, output int kind, output bit mis,
                         output logic [3:0] be, output logic [31:0] wd, output logic [31:0] ld);
        int n;
        bit sgn;
        logic [31:0] mask;
        logic [31:0] v;
        kind = 0; n = 4; sgn = 0;
        case (op)
            6'h20: begin kind = 1; n = 1; sgn = 1; end
            6'h24: begin kind = 1; n = 1; end
            6'h21: begin kind = 1; n = 2; sgn = 1; end
            6'h25: begin kind = 1; n = 2; end
            6'h23: begin kind = 1; n = 4; end
            6'h28: begin kind = 2; n = 1; end
            6'h29: begin kind = 2; n = 2; end
            6'h2B: begin kind = 2; n = 4; end
            default: kind = 0;
        endcase
        mis  = (addr % n) != 0;
        be   = 4'(((1 << n) - 1) << (addr % 4));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
        wd   = (n == 1) ? rd2[7:0] * 32'h0101_0101 : (n == 2) ? rd2[15:0] * 32'h0001_0001 : rd2;
        v    = (rdata >> (8 * (addr % 4))) & mask;
        if (sgn && v[8 * n - 1]) v = v | ~mask;
        ld   = (kind == 1) ? v : 32'h0;
    endtask

    // ack_at: REQ cycle (1-based) in which dm_ack is raised; 0 = never.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rd2,
                          input int ack_at, input logic [31:0] rdata);
        int kind, last;
        bit mis, berr;
        logic [3:0] be;
        logic [31:0] wd, ld;
        model(op, addr, rd2, rdata, kind, mis, be, wd, ld);
        @(negedge CLK);
        Valid = 1'b1; Ins = {op, 26'($urandom)}; Result = addr; Rdata2 = rd2; dm_ack = 1'b0;
        #1;
        if (kind == 0 || mis) begin
            check("idle_stall", Stall, 0);
            check("idle_alignerr", AlignErr, (kind != 0) ? 1 : 0);
            @(negedge CLK);
            Valid = 1'b0;
            #1;
            check("idle_req", dm_req, 0);
            check("idle_alignerr_clr", AlignErr, 0);
            check("idle_done", Done, 0);
            return;
        end
        check("start_stall", Stall, 1);
        check("start_alignerr", AlignErr, 0);
        berr = !(ack_at != 0 && ack_at <= TO);
        last = berr ? TO : ack_at;
        @(negedge CLK);
        Valid = 1'b0; Ins = $urandom; Result = $urandom; Rdata2 = $urandom;
        for (int k = 1; k <= last; k++) begin
            check("req_req", dm_req, 1);
            check("req_stall", Stall, 1);
            check("req_we", dm_we, (kind == 2) ? 1 : 0);
            check("req_be", dm_be, be);
            check("req_addr", dm_addr, {addr[31:2], 2'b00});
            check("req_wdata", dm_wdata, wd);
            check("req_done", Done, 0);
            if (k == ack_at) begin dm_ack = 1'b1; dm_rdata = rdata; end
            else begin dm_ack = 1'b0; dm_rdata = $urandom; end
            @(negedge CLK);
            dm_ack = 1'b0;
        end
        check("done_done", Done, 1);
        check("done_stall", Stall, 0);
        check("done_buserr", BusErr, berr);
        check("done_ldata", Ldata, berr ? 32'h0 : ld);
        check("done_req", dm_req, 0);
        @(negedge CLK);
        check("post_done", Done, 0);
        check("post_req", dm_req, 0);
    endtask

    localparam logic [5:0] OPS [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                                        6'h28, 6'h29, 6'h2B, 6'h00, 6'h08};

    initial begin
        #12;
        check("rst_stall", Stall, 0);
        check("rst_ldata", Ldata, 0);
        check("rst_done", Done, 0);
        check("rst_alignerr", AlignErr, 0);
        check("rst_buserr", BusErr, 0);
        check("rst_req", dm_req, 0);
        check("rst_we", dm_we, 0);
        check("rst_be", dm_be, 0);
        check("rst_addr", dm_addr, 0);
        check("rst_wdata", dm_wdata, 0);
        @(negedge CLK);
        RST = 1'b1;

        run_op(6'h2B, 32'h100, 32'hDEADBEEF, 2, 32'h0);
        run_op(6'h20, 32'h103, 32'h0, 1, 32'h80AABBCC);
        run_op(6'h24, 32'h103, 32'h0, 3, 32'h80AABBCC);
        run_op(6'h21, 32'h102, 32'h0, 1, 32'h80011234);
        run_op(6'h25, 32'h102, 32'h0, 2, 32'h80011234);
        run_op(6'h28, 32'h101, 32'h000000A5, 1, 32'h0);
        run_op(6'h23, 32'h102, 32'h0, 1, 32'h0);
        run_op(6'h29, 32'h101, 32'h0, 1, 32'h0);
        run_op(6'h00, 32'h104, 32'h0, 1, 32'h0);
        run_op(6'h23, 32'h200, 32'h0, 0, 32'h0);
        run_op(6'h23, 32'h204, 32'h0, TO, 32'h12345678);

        // Ack while idle must be ignored.
        @(negedge CLK);
        dm_ack = 1'b1;
        @(negedge CLK);
        dm_ack = 1'b0;
        check("stray_ack_done", Done, 0);
        check("stray_ack_req", dm_req, 0);

        for (int i = 0; i < 80; i++) begin
            int ack;
            ack = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 18)) : int'($urandom_range(1, 4));
            run_op(OPS[$urandom_range(0, 9)], $urandom, $urandom, ack, $urandom);
        end

        // Reset mid-REQ abandons the access.
        @(negedge CLK);
        Valid = 1'b1; Ins = {6'h23, 26'h0}; Result = 32'h300;
        @(negedge CLK);
        Valid = 1'b0;
        @(negedge CLK);
        check("midrst_req_before", dm_req, 1);
        RST = 1'b0;
        #1;
        check("midrst_req", dm_req, 0);
        check("midrst_stall", Stall, 0);
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("midrst_done", Done, 0);
            check("midrst_req_after", dm_req, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
